stage_fetch: RTL

Instruction fetch stage directly upstream of the decode stage. Issues in-order word fetches to the instruction memory bus and buffers returned words with their PCs. Presents pc/instr/instr_valid to decode and honours decode's stall. Flushes on decode's discard and restarts from the execute-supplied redirect target.

---
 rtl/stage_fetch_pkg.sv | 13 +
 rtl/stage_fetch_buffer.sv | 62 ++++++
 rtl/stage_fetch.sv | 105 ++++++++++
 3 files changed

// File: rtl/stage_fetch_pkg.sv
// Shared definitions for the fetch stage: the reset PC, the fetch state
// encoding and the instruction size.
package stage_fetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] INSTR_BYTES      = 32'd4;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/stage_fetch_buffer.sv
// Small synchronous FIFO of {pc, instr} pairs sitting between the memory
// response path and decode; flush beats a simultaneous push or pop.
module fetch_buffer #(
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [31:0]   pushPc_i,
  input  logic [31:0]   pushInstr_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [31:0]   headPc_o,
  output logic [31:0]   headInstr_o,
  output logic [CW-1:0] count_o
);

  logic [63:0]   mem_q [DEPTH];
  logic [PW-1:0] wrPtr_q, rdPtr_q;
  logic [CW-1:0] count_q;
  logic          doPush, doPop;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign doPush = push_i & ~flush_i;
  assign doPop  = pop_i & (count_q != '0) & ~flush_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) begin
        mem_q[wrPtr_q] <= {pushPc_i, pushInstr_i};
        wrPtr_q        <= nextPtr(wrPtr_q);
      end
      if (doPop) rdPtr_q <= nextPtr(rdPtr_q);
      if (doPush && !doPop) count_q <= count_q + CW'(1);
      else if (doPop && !doPush) count_q <= count_q - CW'(1);
    end
  end

  // The issue credit keeps responses from ever arriving at a full buffer.
  always_ff @(posedge clk) begin
    if (rst_n) assert (!(doPush && !doPop && count_q == CW'(DEPTH)));
  end

  assign headPc_o    = (count_q != '0) ? mem_q[rdPtr_q][63:32] : '0;
  assign headInstr_o = (count_q != '0) ? mem_q[rdPtr_q][31:0]  : '0;
  assign count_o     = count_q;

endmodule

// File: rtl/stage_fetch.sv
// Instruction fetch stage: issues in-order word fetches, buffers responses
// with their PCs and hands them to decode, flushing on discard/redirect.
module stage_fetch
  import stage_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = DEFAULT_RESET_PC,
  parameter int          BUF_DEPTH       = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  input  logic        stall,
  input  logic        discard,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc_out,
  output logic [31:0] instr,
  output logic        instr_valid
);

  localparam int OCW = $clog2(MAX_OUTSTANDING + 1);
  localparam int BCW = $clog2(BUF_DEPTH + 1);

  fetch_state_e   state_q, state_d;
  logic [31:0]    fetchPc_q, fetchPc_d, respPc_q, respPc_d;
  logic [OCW-1:0] outstanding_q, outstanding_d, drop_q, drop_d;
  logic [BCW-1:0] bufCount;
  logic           flush, canIssue, grant, push, pop;

  assign flush    = discard | redirect_valid;
  // Buffer credit counts in-flight words so every response has a slot.
  assign canIssue = (state_q == RUN) && !flush
                    && (int'(outstanding_q) < MAX_OUTSTANDING)
                    && (int'(outstanding_q) + int'(bufCount) < BUF_DEPTH);
  assign imem_req    = rst_n & canIssue;
  assign imem_addr   = fetchPc_q;
  assign grant       = imem_req & imem_gnt;
  assign push        = imem_rvalid && (drop_q == '0);
  assign instr_valid = (bufCount != '0);
  assign pop         = instr_valid & ~stall;

  always_comb begin
    state_d       = state_q;
    fetchPc_d     = fetchPc_q;
    respPc_d      = respPc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    if (grant) fetchPc_d = fetchPc_q + INSTR_BYTES;
    case ({grant, imem_rvalid})
      2'b10:   outstanding_d = outstanding_q + OCW'(1);
      2'b01:   outstanding_d = outstanding_q - OCW'(1);
      default: outstanding_d = outstanding_q;
    endcase
    if (imem_rvalid) begin
      if (drop_q != '0) drop_d = drop_q - OCW'(1);
      else respPc_d = respPc_q + INSTR_BYTES;
    end
    if (flush) drop_d = outstanding_d;
    if (discard) state_d = HOLD;
    if (redirect_valid) begin
      state_d   = RUN;
      fetchPc_d = redirect_pc;
      respPc_d  = redirect_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      fetchPc_q     <= RESET_PC;
      respPc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      state_q       <= state_d;
      fetchPc_q     <= fetchPc_d;
      respPc_q      <= respPc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) assert (!(imem_rvalid && outstanding_q == '0));
  end

  fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buffer (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .pushPc_i   (respPc_q),
    .pushInstr_i(imem_rdata),
    .pop_i      (pop),
    .flush_i    (flush),
    .headPc_o   (pc_out),
    .headInstr_o(instr),
    .count_o    (bufCount)
  );

endmodule
